// File: rtl/imm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_pkg                                                         |
// | Purpose  : Shared immediate-format encodings, request beat type and a      |
// |            range helper for the immediate encoder.                         |
// | Contents : IMM_I/S/B/J/U, ARM_IMM8/IMM12/BR24 codes, imm_req_t,            |
// |            upper_uniform()                                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package imm_pkg;

  // RISC-V immsrc codes (arm = 0), same encoding as the decode-stage extender
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b111;

  // ARM immsrc codes (arm = 1); only bits [1:0] are significant
  localparam logic [2:0] ARM_IMM8  = 3'b000;
  localparam logic [2:0] ARM_IMM12 = 3'b001;
  localparam logic [2:0] ARM_BR24  = 3'b010;

  // One request beat as captured by the first pipeline stage
  typedef struct packed {
    logic        arm;
    logic [2:0]  immsrc;
    logic [31:0] base;
    logic [31:0] imm;
  } imm_req_t;

  // True when v[31:msb] are all copies of the sign bit, i.e. v fits a
  // signed field whose top bit sits at position msb.
  function automatic logic upper_uniform(input logic [31:0] v, input int unsigned msb);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> msb);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_pack                                                        |
// | Purpose  : Combinational packing of a 32-bit immediate into the selected   |
// |            instruction format plus representability check.                |
// | Ports    : req_i   - request beat (arm, immsrc, base, imm)                 |
// |            instr_o - base with the selected immediate field(s) replaced    |
// |            err_o   - imm not representable or format undefined            |
// | Config   : COMBI_ARM_EN - builds the ARM formats; otherwise arm is ignored |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module imm_pack
  import imm_pkg::*;
(
  input  imm_req_t    req_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic [31:0] imm;
  assign imm = req_i.imm;

`ifndef COMBI_ARM_EN
  // Without the ARM formats the mode bit has no effect.
  logic unused_arm;
  assign unused_arm = req_i.arm;
`endif

  // Undefined formats fall through the defaults: word unchanged, err set.
  // Illegal but defined formats still pack the truncated bits.
  always_comb begin
    instr_o = req_i.base;
    err_o   = 1'b1;
`ifdef COMBI_ARM_EN
    if (req_i.arm) begin
      case (req_i.immsrc[1:0])
        ARM_IMM8[1:0]: begin
          instr_o[7:0] = imm[7:0];
          err_o        = |imm[31:8];
        end
        ARM_IMM12[1:0]: begin
          instr_o[11:0] = imm[11:0];
          err_o         = |imm[31:12];
        end
        ARM_BR24[1:0]: begin
          // word offset: byte offset with the two zero LSBs dropped
          instr_o[23:0] = imm[25:2];
          err_o         = (|imm[1:0]) | ~upper_uniform(imm, 25);
        end
        default: ;
      endcase
    end else
`endif
    begin
      case (req_i.immsrc)
        IMM_I: begin
          instr_o[31:20] = imm[11:0];
          err_o          = ~upper_uniform(imm, 11);
        end
        IMM_S: begin
          instr_o[31:25] = imm[11:5];
          instr_o[11:7]  = imm[4:0];
          err_o          = ~upper_uniform(imm, 11);
        end
        IMM_B: begin
          instr_o[31]    = imm[12];
          instr_o[7]     = imm[11];
          instr_o[30:25] = imm[10:5];
          instr_o[11:8]  = imm[4:1];
          err_o          = imm[0] | ~upper_uniform(imm, 12);
        end
        IMM_J: begin
          instr_o[31]    = imm[20];
          instr_o[19:12] = imm[19:12];
          instr_o[20]    = imm[11];
          instr_o[30:21] = imm[10:1];
          err_o          = imm[0] | ~upper_uniform(imm, 20);
        end
        IMM_U: begin
          instr_o[31:12] = imm[31:12];
          err_o          = |imm[11:0];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imm_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_encode                                                      |
// | Purpose  : Two-stage valid/ready pipeline that packs an immediate into an  |
// |            instruction word (RISC-V I/S/B/J/U or ARM imm8/imm12/br24) and  |
// |            flags unrepresentable values, with a saturating error counter.  |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            in_valid/in_ready, arm, immsrc, base, imm  - request side       |
// |            out_valid/out_ready, instr, err             - result side       |
// |            err_count - saturating count of delivered error beats          |
// | Config   : COMBI_ARM_EN - enables ARM formats (in imm_pack)                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module imm_encode
  import imm_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 arm,
  input  logic [2:0]           immsrc,
  input  logic [31:0]          base,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Stage 1: registered request
  logic     s1_valid_q, s1_valid_d;
  imm_req_t s1_req_q, s1_req_d;
  // Stage 2: registered packed result
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q, s2_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  imm_req_t    req_in;
  logic [31:0] pack_instr;
  logic        pack_err;
  logic        s1_move, s1_load, s2_move;

  assign req_in.arm    = arm;
  assign req_in.immsrc = immsrc;
  assign req_in.base   = base;
  assign req_in.imm    = imm;

  // S1 advances when S2 is empty or S2 is draining this cycle; in_ready
  // therefore depends combinationally on out_ready.
  assign s1_move  = s1_valid_q & (~s2_valid_q | out_ready);
  assign s2_move  = s2_valid_q & out_ready;
  assign in_ready = ~s1_valid_q | s1_move;
  assign s1_load  = in_valid & in_ready;

  imm_pack u_pack (
    .req_i   (s1_req_q),
    .instr_o (pack_instr),
    .err_o   (pack_err)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    s2_valid_d  = s2_valid_q;
    s2_instr_d  = s2_instr_q;
    s2_err_d    = s2_err_q;
    err_count_d = err_count_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_req_d   = req_in;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    // S2 only reloads when it is empty or draining, so its contents stay
    // stable while stalled.
    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_instr_d = pack_instr;
      s2_err_d   = pack_err;
    end else if (s2_move) begin
      s2_valid_d = 1'b0;
    end

    if (s2_move && s2_err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= '0;
      s2_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = s2_instr_q;
  assign err       = s2_err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_imm_encode                                                   |
// | Purpose  : Self-checking bench for imm_encode with a scoreboard queue.     |
// | Config   : COMBI_ARM_EN - expectations follow the same build option        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_imm_encode;

  localparam int unsigned ERR_CNT_W = 16;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 arm;
  logic [2:0]           immsrc;
  logic [31:0]          base;
  logic [31:0]          imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          instr;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;

  imm_encode #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .arm       (arm),
    .immsrc    (immsrc),
    .base      (base),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   wait_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: field mask/contents built from shifts; legality from the
  // signed range of the value.
  function automatic logic [32:0] model(input logic a, input logic [2:0] src,
                                        input logic [31:0] b, input logic [31:0] v);
    longint      s;
    logic [31:0] m;
    logic [31:0] f;
    logic        e;
    logic        use_arm;
    s = longint'($signed(v));
    m = '0;
    f = '0;
    e = 1'b1;
`ifdef COMBI_ARM_EN
    use_arm = a;
`else
    use_arm = a & 1'b0;
`endif
    if (use_arm) begin
      case (src[1:0])
        2'd0: begin m = 32'h0000_00FF; f = v; e = (v > 32'd255); end
        2'd1: begin m = 32'h0000_0FFF; f = v; e = (v > 32'd4095); end
        2'd2: begin
          m = 32'h00FF_FFFF; f = v >> 2;
          e = (v[1:0] != 2'b00) || (s < -33554432) || (s > 33554431);
        end
        default: ;
      endcase
    end else begin
      case (src)
        3'b000: begin m = 32'hFFF0_0000; f = v << 20; e = (s < -2048) || (s > 2047); end
        3'b001: begin
          m = 32'hFE00_0F80;
          f = (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
          e = (s < -2048) || (s > 2047);
        end
        3'b010: begin
          m = 32'hFE00_0F80;
          f = (((v >> 12) & 32'h1) << 31) | (((v >> 11) & 32'h1) << 7) |
              (((v >> 5) & 32'h3F) << 25) | (((v >> 1) & 32'hF) << 8);
          e = v[0] || (s < -4096) || (s > 4095);
        end
        3'b011: begin
          m = 32'hFFFF_F000;
          f = (((v >> 20) & 32'h1) << 31) | (v & 32'h000F_F000) |
              (((v >> 11) & 32'h1) << 20) | (((v >> 1) & 32'h3FF) << 21);
          e = v[0] || (s < -1048576) || (s > 1048575);
        end
        3'b111: begin m = 32'hFFFF_F000; f = v; e = (v[11:0] != 12'h000); end
        default: ;
      endcase
    end
    return {e, (b & ~m) | (f & m)};
  endfunction

  // Called in the drive phase (#1 after posedge); returns in the same phase
  // right after the beat is accepted. in_valid is left high.
  task automatic send_exp(input logic a, input logic [2:0] src, input logic [31:0] b,
                          input logic [31:0] v, input logic [31:0] ei, input logic ee);
    bit   done;
    exp_t x;
    arm = a; immsrc = src; base = b; imm = v; in_valid = 1'b1;
    x.instr = ei;
    x.err   = ee;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(x);
        done = 1'b1;
      end else begin
        wait_cycles++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept timeout", 32'(done), 32'd1);
  endtask

  task automatic send(input logic a, input logic [2:0] src, input logic [31:0] b,
                      input logic [31:0] v);
    logic [32:0] r;
    r = model(a, src, b, v);
    send_exp(a, src, b, v, r[31:0], r[32]);
  endtask

  task automatic drain();
    bit empty;
    in_valid = 1'b0;
    empty = 1'b0;
    for (int k = 0; k < 20 && !empty; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) empty = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("drain queue", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: pop the oldest expectation on each delivered beat.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious beat", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("err", 32'(err), 32'(e.err));
        n_out++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] r1;
    int          out_base;
    logic [31:0] v;

    reset = 1'b1; in_valid = 1'b0; arm = 1'b0; immsrc = '0;
    base = '0; imm = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // I format, two-cycle latency
    out_ready = 1'b1;
    send_exp(1'b0, 3'b000, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency N+1 out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("latency N+2 out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // B format: legal edge, then just out of range
    send_exp(1'b0, 3'b010, 32'h0000_0063, 32'h0000_0800, 32'h0000_00E3, 1'b0);
    send_exp(1'b0, 3'b010, 32'h0000_0063, 32'h0000_1000, 32'h8000_0063, 1'b1);
    drain();
    chk("err_count after B", 32'(err_count), 32'd1);

    // U with nonzero low bits; undefined RISC-V code
    send_exp(1'b0, 3'b111, 32'h0000_0037, 32'h1234_5001, 32'h1234_5037, 1'b1);
    send_exp(1'b0, 3'b100, 32'hDEAD_BEEF, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1);

    // ARM branch (or RISC-V B when the ARM formats are not built)
`ifdef COMBI_ARM_EN
    send_exp(1'b1, 3'b010, 32'hEA00_0000, 32'hFFFF_FFF8, 32'hEAFF_FFFE, 1'b0);
`else
    send_exp(1'b1, 3'b010, 32'hEA00_0000, 32'hFFFF_FFF8, 32'hFE00_0C80, 1'b0);
`endif
    drain();
    chk("err_count after U/undef", 32'(err_count), 32'd3);

    // Back-to-back random beats: no stalls with out_ready high
    wait_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      v = $urandom;
      if (k % 2 == 0) v = 32'($signed(v) >>> 19);
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, v);
    end
    chk("throughput stalls", 32'(wait_cycles), 32'd0);
    drain();

    // Backpressure: two beats fill the pipe, third is refused
    out_base = n_out;
    out_ready = 1'b0;
    r1 = model(1'b0, 3'b001, 32'h1111_1111, 32'hFFFF_F800);
    send(1'b0, 3'b001, 32'h1111_1111, 32'hFFFF_F800);
    send(1'b0, 3'b011, 32'h2222_2222, 32'h000F_FFFE);
    arm = 1'b0; immsrc = 3'b000; base = 32'h3333_3333; imm = 32'h0000_07FF;
    @(negedge clk);
    chk("bp in_ready full", 32'(in_ready), 32'd0);
    chk("bp out_valid held", 32'(out_valid), 32'd1);
    chk("bp instr held 1", instr, r1[31:0]);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp instr held 2", instr, r1[31:0]);
    chk("bp err held", 32'(err), 32'(r1[32]));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1'b0, 3'b000, 32'h3333_3333, 32'h0000_07FF);
    drain();
    chk("bp beats delivered", 32'(n_out - out_base), 32'd3);

    // Reset with both stages full and a nonzero error count
    out_ready = 1'b0;
    send(1'b0, 3'b101, 32'h4444_4444, 32'h0);
    send(1'b0, 3'b110, 32'h5555_5555, 32'h0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst err_count", 32'(err_count), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;

    // Saturation of the error counter
    for (int k = 0; k < 65534; k++) begin
      send_exp(1'b0, 3'b100, 32'hCAFE_0000, 32'(k), 32'hCAFE_0000, 1'b1);
    end
    drain();
    chk("err_count below sat", 32'(err_count), 32'h0000_FFFE);
    for (int k = 0; k < 4466; k++) begin
      send_exp(1'b0, 3'b100, 32'hCAFE_0001, 32'(k), 32'hCAFE_0001, 1'b1);
    end
    drain();
    chk("err_count saturated", 32'(err_count), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
